// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the counter sequencing controller.
// Imported by count_ctrl and count_prescaler.
package count_ctrl_pkg;

    localparam int STATE_W     = 3;
    localparam int DEF_WIDTH   = 16;
    localparam int DEF_PRESC_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

endpackage

// File: rtl/count_prescaler.sv
// Down-counting prescaler: ticks at zero then reloads; frozen when not running.
// Loaded from the latched reload value while the controller clears the counter.
module count_prescaler
    import count_ctrl_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               run_i,
    input  logic [PRESC_W-1:0] reload_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick_o = run_i && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = reload_i;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? reload_i : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Start/stop/clear sequencer for an enable-driven up-counter with terminal limit.
// Define COUNT_CTRL_PRESCALE_EN to pace increments through count_prescaler.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               clear_i,
    input  logic               mode_i,
    input  logic [WIDTH-1:0]   limit_i,
    input  logic [PRESC_W-1:0] presc_i,
    input  logic [WIDTH-1:0]   cnt_q_i,
    output logic               cnt_en_o,
    output logic               cnt_clr_n_o,
    output logic               done_o,
    output logic               busy_o,
    output logic [STATE_W-1:0] state_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             done_q, done_d;
    logic             clr_n_q, clr_n_d;
    logic             latch;
    logic             tick;
    logic             terminal;

    assign terminal = (cnt_q_i == limit_q);

`ifdef COUNT_CTRL_PRESCALE_EN
    logic [PRESC_W-1:0] presc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else if (latch) begin
            presc_q <= presc_i;
        end
    end

    count_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (state_q == ST_CLR),
        .run_i   (state_q == ST_RUN),
        .reload_i(presc_q),
        .tick_o  (tick)
    );
`else
    logic unused_presc;
    assign unused_presc = ^presc_i;
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CLR;
                    latch   = 1'b1;
                end
            end
            ST_CLR: begin
                state_d = stop_i ? ST_PAUSE : ST_RUN;
            end
            ST_RUN: begin
                if (terminal) begin
                    state_d = mode_i ? ST_CLR : ST_HOLD;
                end else if (stop_i) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop_i) begin
                    state_d = ST_PAUSE;
                end else if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (start_i) begin
                    state_d = ST_CLR;
                    latch   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides every other command, including a terminal hit.
        if (clear_i) begin
            state_d = ST_IDLE;
            latch   = 1'b0;
        end
    end

    assign limit_d = latch ? limit_i : limit_q;
    assign done_d  = (state_q == ST_RUN) && terminal && !clear_i;
    assign clr_n_d = !(clear_i || state_d == ST_CLR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            limit_q <= '0;
            done_q  <= 1'b0;
            clr_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            done_q  <= done_d;
            clr_n_q <= clr_n_d;
        end
    end

    assign cnt_en_o    = (state_q == ST_RUN) && tick && !terminal;
    assign cnt_clr_n_o = clr_n_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q == ST_CLR) || (state_q == ST_RUN) ||
                         (state_q == ST_PAUSE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Scoreboarded bench for count_ctrl driving a behavioural 16-bit counter.
// Expected done pulses are queued by stimulus and checked by a monitor.
module tb_count_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

`ifdef COUNT_CTRL_PRESCALE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] limit = '0;
    logic [7:0]  presc = '0;
    logic [15:0] cnt_q;
    logic        cnt_en;
    logic        cnt_clr_n;
    logic        done;
    logic        busy;
    logic [2:0]  state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  st;
        logic [15:0] cnt;
    } exp_t;
    exp_t q[$];

    count_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .clear_i    (clear),
        .mode_i     (mode),
        .limit_i    (limit),
        .presc_i    (presc),
        .cnt_q_i    (cnt_q),
        .cnt_en_o   (cnt_en),
        .cnt_clr_n_o(cnt_clr_n),
        .done_o     (done),
        .busy_o     (busy),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the external counter
    always @(posedge clk or negedge cnt_clr_n) begin
        if (!cnt_clr_n) cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 16'd1;
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (cyc != e.cyc || state !== e.st || cnt_q !== e.cnt) begin
                    errors++;
                    $display("FAIL done_event: got cyc=%0d st=%0d cnt=%0d want cyc=%0d st=%0d cnt=%0d",
                             cyc, state, cnt_q, e.cyc, e.st, e.cnt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] st, input logic [15:0] cnt);
        exp_t e;
        e.cyc = c;
        e.st  = st;
        e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic issue_start(input logic [15:0] l, input logic [7:0] p, input logic m,
                               output int c0);
        c0    = cyc;
        limit = l;
        presc = p;
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int pe1;
        int per;
        int d1;
        int ens;
        int s;
        logic [15:0] cq;

        // Reset
        step();
        step();
        chk("rst_clr_n", cnt_clr_n, 0);
        chk("rst_state", state, S_IDLE);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_en", cnt_en, 0);
        rst = 1'b0;
        step();
        chk("post_rst_clr_n", cnt_clr_n, 1);
        chk("post_rst_done", done, 0);
        step();

        // One-shot, L=3, P=0
        issue_start(16'd3, 8'd0, 1'b0, c0);
        push(c0 + 6, S_HOLD, 16'd3);
        chk("os_clr_state", state, S_CLR);
        chk("os_clr_n", cnt_clr_n, 0);
        chk("os_busy", busy, 1);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("os_en_c%0d", k), cnt_en, (k >= 2 && k <= 4) ? 1 : 0);
            step();
        end
        chk("os_hold_state", state, S_HOLD);
        chk("os_hold_cnt", cnt_q, 3);
        chk("os_hold_busy", busy, 0);
        clear_pulse();
        chk("os_clear_state", state, S_IDLE);
        chk("os_clear_clr_n", cnt_clr_n, 0);
        step();

        // Periodic, L=2, P=1
        pe1 = PE ? 2 : 1;
        issue_start(16'd2, 8'd1, 1'b1, c0);
        d1  = c0 + 2 * pe1 + 3;
        per = 2 * pe1 + 2;
        for (int k = 0; k < 3; k++) push(d1 + k * per, S_CLR, 16'd0);
        while (cyc < d1 + 2 * per + 1) begin
            if (cnt_q > 16'd2) chk("per_cnt_range", cnt_q, 2);
            step();
        end
        chk("per_run_state", state, S_RUN);
        clear_pulse();
        chk("per_clear_state", state, S_IDLE);
        step();

        // Pause/resume, L=5, P=2
        pe1 = PE ? 3 : 1;
        issue_start(16'd5, 8'd2, 1'b0, c0);
        begin
            int w;
            w = 0;
            while (cnt_q != 16'd2 && w < 200) begin
                step();
                w++;
            end
        end
        chk("pause_reach", cnt_q, 2);
        s = cyc;
        push(c0 + 5 * pe1 + 3 + 4, S_HOLD, 16'd5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("pause_state", state, S_PAUSE);
        cq = cnt_q;
        step();
        step();
        step();
        chk("pause_cyc", cyc, s + 4);
        chk("pause_frozen", cnt_q, cq);
        chk("pause_en", cnt_en, 0);
        chk("pause_state2", state, S_PAUSE);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("resume_state", state, S_RUN);
        while (cyc < c0 + 5 * pe1 + 3 + 6) step();
        chk("pause_hold", state, S_HOLD);
        clear_pulse();
        step();

        // Clear together with stop and start during RUN
        issue_start(16'd10, 8'd0, 1'b0, c0);
        step();
        step();
        step();
        clear = 1'b1;
        stop  = 1'b1;
        start = 1'b1;
        step();
        clear = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        chk("abort_state", state, S_IDLE);
        chk("abort_clr_n", cnt_clr_n, 0);
        chk("abort_cnt", cnt_q, 0);
        chk("abort_busy", busy, 0);
        step();
        chk("abort_clr_n_rel", cnt_clr_n, 1);
        step();
        step();

        // L=0 one-shot, then periodic restart from HOLD
        ens = 0;
        issue_start(16'd0, 8'd0, 1'b0, c0);
        push(c0 + 3, S_HOLD, 16'd0);
        for (int k = 0; k < 5; k++) begin
            if (cnt_en) ens++;
            step();
        end
        chk("l0_hold", state, S_HOLD);
        issue_start(16'd0, 8'd0, 1'b1, c0);
        chk("l0_relatch_clr", state, S_CLR);
        push(c0 + 3, S_CLR, 16'd0);
        push(c0 + 5, S_CLR, 16'd0);
        push(c0 + 7, S_CLR, 16'd0);
        while (cyc < c0 + 8) begin
            if (cnt_en) ens++;
            step();
        end
        chk("l0_term_state", state, S_RUN);
        clear_pulse();
        chk("l0_cnt_en_count", ens, 0);
        step();
        step();

        // Terminal and stop in the same cycle, periodic L=1
        issue_start(16'd1, 8'd0, 1'b1, c0);
        push(c0 + 4, S_CLR, 16'd0);
        while (cyc < c0 + 3) step();
        chk("ts_term_cnt", cnt_q, 1);
        stop = 1'b1;
        step();
        chk("ts_clr_state", state, S_CLR);
        step();
        stop = 1'b0;
        chk("ts_pause_state", state, S_PAUSE);
        clear_pulse();
        step();

        // Asynchronous reset mid-run
        issue_start(16'd10, 8'd0, 1'b0, c0);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", state, S_IDLE);
        chk("arst_en", cnt_en, 0);
        chk("arst_clr_n", cnt_clr_n, 0);
        chk("arst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        step();

        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
